axis2fifo_buf: RTL and testbench
================================

Name: axis2fifo_buf

Overview:
- Parametrised successor to the pass-through AXI-Stream-to-FIFO-read adapter in the accelerator adapter library.
- Accepts one AXI-Stream transaction per CTRL_ALLOW into an internal DEPTH-entry buffer, then presents it on a first-word-fall-through FIFO read interface.
- A transaction ends on TLAST or on an optional programmed beat count.
- Reports completion, beat count and truncation to the control side. Sits between a DMA stream master and an HLS accelerator FIFO input.

Parameters:
- DATA_WIDTH, 64, width of AXIS_TDATA and FIFO_DOUT.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- CNT_WIDTH, 16, width of CTRL_LEN and CTRL_COUNT.
- EMPTY_ACTIVE, 0, FIFO_EMPTY polarity: 1 means high when no data, 0 means low when no data.

Ports:
- ACC_CLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- CTRL_ALLOW  in  1  start-transaction request; sampled only in IDLE.
- CTRL_LEN  in  CNT_WIDTH  beat limit, latched at start; 0 means no limit (TLAST only).
- CTRL_READY  out  1  high in IDLE.
- CTRL_FINISHED  out  1  one-cycle pulse when a transaction has ended and its data has drained.
- CTRL_TRUNC  out  1  valid with CTRL_FINISHED; 1 if the transaction ended on the limit without TLAST.
- CTRL_COUNT  out  CNT_WIDTH  beats accepted in the current or last transaction.
- AXIS_TVALID  in  1  stream valid.
- AXIS_TLAST  in  1  stream last.
- AXIS_TDATA  in  DATA_WIDTH  stream data.
- AXIS_TREADY  out  1  stream ready.
- FIFO_EMPTY  out  1  no-data indication; polarity set by EMPTY_ACTIVE.
- FIFO_DOUT  out  DATA_WIDTH  head-of-buffer word (FWFT).
- FIFO_READ  in  1  pop request.

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - state=IDLE; buffer pointers and occupancy cleared; all buffered data discarded.
  - CTRL_COUNT=0, CTRL_READY=1, CTRL_FINISHED=0, CTRL_TRUNC=0, AXIS_TREADY=0, FIFO_DOUT=0.
  - FIFO_EMPTY at its "no data" level.
  - Reset mid-transaction behaves identically; no FINISHED pulse is produced.
- State machine:
  - IDLE: CTRL_READY=1, AXIS_TREADY=0. If CTRL_ALLOW=1, latch CTRL_LEN, clear CTRL_COUNT, go to RUN.
  - RUN: AXIS_TREADY = ~full (registered occupancy; no same-cycle pop credit). A beat is accepted when TVALID&&TREADY: write buffer, increment CTRL_COUNT.
    - Accepted beat with TLAST=1: go to DRAIN, trunc=0.
    - Accepted beat without TLAST and (LEN!=0 && COUNT+1==LEN): go to DRAIN, trunc=1.
    - Accepted beat with TLAST=1 and COUNT+1==LEN: trunc=0.
  - DRAIN: AXIS_TREADY=0. When occupancy==0 (including the cycle the last word is popped), go to DONE.
  - DONE: CTRL_FINISHED=1 and CTRL_TRUNC=trunc for exactly one cycle, then IDLE. CTRL_COUNT holds until the next start.
- CTRL_ALLOW outside IDLE is ignored. CTRL_ALLOW held high restarts one cycle after DONE.
- FIFO side is active in all states:
  - Data present when occupancy>0. FIFO_DOUT equals the head word combinationally from the registered head.
  - Pop when FIFO_READ && present. FIFO_READ while empty is ignored; no pointer change.
  - Push and pop in the same cycle leave occupancy unchanged.
- Latency: a beat accepted at edge N is visible on FIFO_DOUT with the empty flag deasserted after edge N (one cycle).
- Full: occupancy==DEPTH forces AXIS_TREADY=0 in the following cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- CTRL_COUNT saturates at all-ones and never wraps.

Test Plan:
- Basic TLAST transaction: reset, LEN=0, ALLOW pulse, send 5 beats 0x10..0x14 with TLAST on the 5th, FIFO_READ held high -> FIFO_DOUT sequence 0x10..0x14; FINISHED pulses once after the last pop; COUNT=5; TRUNC=0.
- Length truncation: LEN=3, stream of 6 beats with no TLAST -> only 3 beats accepted, TREADY=0 from the cycle after the 3rd; FINISHED with TRUNC=1; COUNT=3.
- Backpressure and wrap: DEPTH=16, FIFO_READ=0, send 20 beats -> TREADY drops after 16 accepted. Then read 1 per 3 cycles -> all 20 values in order across pointer wrap; no loss or duplication.
- Polarity and empty reads: EMPTY_ACTIVE=0 and 1 builds; FIFO_READ pulsed while empty -> pointers unchanged, FIFO_EMPTY at the correct level, no spurious data.
- Simultaneous TLAST and limit: LEN=4, TLAST on the 4th beat -> TRUNC=0, COUNT=4.
- Mid-run reset: assert ARESET after 7 of 10 beats -> next cycle TREADY=0, empty flag asserted, COUNT=0, no FINISHED. A new transaction afterwards starts clean.

Source files
------------

// File: rtl/axis2fifo_buf.sv
// AXI-Stream to first-word-fall-through FIFO adapter with an internal DEPTH-entry buffer.
// One stream transaction per CTRL_ALLOW; ends on TLAST or an optional programmed beat limit.
module axis2fifo_buf #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter bit          EMPTY_ACTIVE = 1'b0
) (
  input  logic                  ACC_CLK,
  input  logic                  ARESET,
  input  logic                  CTRL_ALLOW,
  input  logic [CNT_WIDTH-1:0]  CTRL_LEN,
  output logic                  CTRL_READY,
  output logic                  CTRL_FINISHED,
  output logic                  CTRL_TRUNC,
  output logic [CNT_WIDTH-1:0]  CTRL_COUNT,
  input  logic                  AXIS_TVALID,
  input  logic                  AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0] AXIS_TDATA,
  output logic                  AXIS_TREADY,
  output logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] FIFO_DOUT,
  input  logic                  FIFO_READ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullOcc = DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  trunc_q, trunc_d;

  logic                  present;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  at_limit;
  logic [CNT_WIDTH:0]    count_inc;
  logic [CNT_WIDTH-1:0]  count_sat;

  assign present   = (occ_q != '0);
  assign full      = (occ_q == FullOcc);
  assign push      = AXIS_TVALID && AXIS_TREADY;
  assign pop       = FIFO_READ && present;
  assign count_inc = {1'b0, count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // Limit compares against the unsaturated increment; a zero length disables it.
  assign at_limit  = (len_q != '0) && (count_inc == {1'b0, len_q});
  assign count_sat = (&count_q) ? count_q : count_inc[CNT_WIDTH-1:0];

  // State register
  always_ff @(posedge ACC_CLK) begin
    if (ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (CTRL_ALLOW) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (push && (AXIS_TLAST || at_limit)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (occ_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs; TREADY uses registered occupancy only, no same-cycle pop credit.
  always_comb begin
    CTRL_READY    = 1'b0;
    CTRL_FINISHED = 1'b0;
    CTRL_TRUNC    = 1'b0;
    AXIS_TREADY   = 1'b0;
    unique case (state_q)
      StIdle: CTRL_READY = 1'b1;
      StRun:  AXIS_TREADY = !full;
      StDrain: begin
      end
      StDone: begin
        CTRL_FINISHED = 1'b1;
        CTRL_TRUNC    = trunc_q;
      end
      default: begin
      end
    endcase
  end

  // Datapath next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    len_d    = len_q;
    trunc_d  = trunc_q;

    if ((state_q == StIdle) && CTRL_ALLOW) begin
      len_d   = CTRL_LEN;
      count_d = '0;
      trunc_d = 1'b0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_sat;
      if (AXIS_TLAST) begin
        trunc_d = 1'b0;
      end else if (at_limit) begin
        trunc_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (AW + 1)'(1);
      2'b01:   occ_d = occ_q - (AW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge ACC_CLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      len_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once occupancy is cleared.
  always_ff @(posedge ACC_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= AXIS_TDATA;
    end
  end

  assign CTRL_COUNT = count_q;
  assign FIFO_DOUT  = present ? mem_q[rd_ptr_q] : '0;
  assign FIFO_EMPTY = EMPTY_ACTIVE ? !present : present;

endmodule

// File: tb/tb_axis2fifo_buf.sv
// Self-checking bench for axis2fifo_buf: a queue-based transaction model checks both
// FIFO_EMPTY polarities every cycle under directed and randomized stimulus.
module tb_axis2fifo_buf;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic          clk;
  logic          arst;
  logic          allow;
  logic [CW-1:0] ctrl_len;
  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic          fread;

  logic          ready0, fin0, trunc0, tready0, empty0;
  logic [CW-1:0] count0;
  logic [DW-1:0] dout0;
  logic          ready1, fin1, trunc1, tready1, empty1;
  logic [CW-1:0] count1;
  logic [DW-1:0] dout1;

  axis2fifo_buf #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (CW),
    .EMPTY_ACTIVE(1'b0)
  ) u_dut0 (
    .ACC_CLK      (clk),
    .ARESET       (arst),
    .CTRL_ALLOW   (allow),
    .CTRL_LEN     (ctrl_len),
    .CTRL_READY   (ready0),
    .CTRL_FINISHED(fin0),
    .CTRL_TRUNC   (trunc0),
    .CTRL_COUNT   (count0),
    .AXIS_TVALID  (tvalid),
    .AXIS_TLAST   (tlast),
    .AXIS_TDATA   (tdata),
    .AXIS_TREADY  (tready0),
    .FIFO_EMPTY   (empty0),
    .FIFO_DOUT    (dout0),
    .FIFO_READ    (fread)
  );

  axis2fifo_buf #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (CW),
    .EMPTY_ACTIVE(1'b1)
  ) u_dut1 (
    .ACC_CLK      (clk),
    .ARESET       (arst),
    .CTRL_ALLOW   (allow),
    .CTRL_LEN     (ctrl_len),
    .CTRL_READY   (ready1),
    .CTRL_FINISHED(fin1),
    .CTRL_TRUNC   (trunc1),
    .CTRL_COUNT   (count1),
    .AXIS_TVALID  (tvalid),
    .AXIS_TLAST   (tlast),
    .AXIS_TDATA   (tdata),
    .AXIS_TREADY  (tready1),
    .FIFO_EMPTY   (empty1),
    .FIFO_DOUT    (dout1),
    .FIFO_READ    (fread)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  logic [DW-1:0] mq[$];
  int            m_phase = 0;
  int            m_len   = 0;
  int            m_count = 0;
  bit            m_trunc = 1'b0;
  bit            m_acc   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks all outputs against the model, advances the model, then moves one clock.
  task automatic cycle();
    int            n;
    logic          exp_tr;
    logic [DW-1:0] exp_dout;
    int            old_count;
    n        = mq.size();
    exp_tr   = (m_phase == 1) && (n < DEPTH);
    exp_dout = (n > 0) ? mq[0] : '0;
    check("ready0",  ready0,  m_phase == 0);
    check("fin0",    fin0,    m_phase == 3);
    check("trunc0",  trunc0,  (m_phase == 3) && m_trunc);
    check("count0",  count0,  m_count);
    check("tready0", tready0, exp_tr);
    check("empty0",  empty0,  n > 0);
    check("dout0",   dout0,   exp_dout);
    check("ready1",  ready1,  m_phase == 0);
    check("fin1",    fin1,    m_phase == 3);
    check("trunc1",  trunc1,  (m_phase == 3) && m_trunc);
    check("count1",  count1,  m_count);
    check("tready1", tready1, exp_tr);
    check("empty1",  empty1,  n == 0);
    check("dout1",   dout1,   exp_dout);

    m_acc = 1'b0;
    if (arst) begin
      mq.delete();
      m_phase = 0;
      m_count = 0;
      m_trunc = 1'b0;
    end else begin
      if (fread && (n > 0)) void'(mq.pop_front());
      case (m_phase)
        0: begin
          if (allow) begin
            m_phase = 1;
            m_len   = int'(ctrl_len);
            m_count = 0;
            m_trunc = 1'b0;
          end
        end
        1: begin
          if (tvalid && exp_tr) begin
            m_acc = 1'b1;
            mq.push_back(tdata);
            old_count = m_count;
            if (m_count < (1 << CW) - 1) m_count++;
            if (tlast) begin
              m_phase = 2;
              m_trunc = 1'b0;
            end else if ((m_len != 0) && (old_count + 1 == m_len)) begin
              m_phase = 2;
              m_trunc = 1'b1;
            end
          end
        end
        2: if (mq.size() == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // rmode: 1 read always, 2 read random, 3 stall 25 cycles then read every third cycle.
  task automatic run_txn(input int len_v, input int nbeats, input int last_idx,
                         input int rmode, input bit gaps, input logic [DW-1:0] base,
                         input bit hold_allow);
    int            sent;
    int            cyc;
    logic [DW-1:0] cur;
    sent = 0;
    cur  = (base != 0) ? base : {$urandom, $urandom};
    allow    = 1'b1;
    ctrl_len = CW'(len_v);
    tvalid   = 1'b0;
    fread    = 1'b0;
    cycle();
    if (!hold_allow) allow = 1'b0;
    for (cyc = 0; (cyc < 600) && (m_phase != 0); cyc++) begin
      if ((rmode == 3) && (cyc == 25)) begin
        check("bp_count", count0, DEPTH);
        check("bp_tready", tready0, 1'b0);
      end
      tvalid = (sent < nbeats) && (!gaps || ($urandom_range(0, 1) == 1));
      tdata  = cur;
      tlast  = (sent == last_idx);
      case (rmode)
        1:       fread = 1'b1;
        2:       fread = ($urandom_range(0, 2) != 0);
        3:       fread = (cyc >= 25) && (cyc % 3 == 0);
        default: fread = 1'b0;
      endcase
      cycle();
      if (m_acc) begin
        sent++;
        cur = (base != 0) ? base + DW'(sent) : {$urandom, $urandom};
      end
    end
    if (m_phase != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL txn_timeout: observed phase %0d expected idle", m_phase);
    end
    allow  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    fread  = 1'b0;
  endtask

  initial begin
    int sent;
    int len_v;
    int nb;
    int last;
    arst     = 1'b1;
    allow    = 1'b0;
    ctrl_len = '0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdata    = '0;
    fread    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cycle();
    arst = 1'b0;
    cycle();

    // Basic TLAST transaction
    run_txn(0, 5, 4, 1, 1'b0, 64'h10, 1'b0);
    check("basic_count", count0, 5);

    // Length truncation: six beats offered, three taken
    run_txn(3, 6, -1, 1, 1'b0, 64'h0, 1'b0);
    check("trunc_count", count0, 3);

    // Backpressure and pointer wrap
    run_txn(0, 20, 19, 3, 1'b0, 64'h0, 1'b0);
    check("bp_final_count", count0, 20);

    // Reads while empty must not disturb the pointers
    fread = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    fread = 1'b0;
    run_txn(0, 3, 2, 2, 1'b0, 64'h0, 1'b0);

    // Simultaneous TLAST and limit
    run_txn(4, 4, 3, 2, 1'b0, 64'h0, 1'b0);
    check("simul_count", count0, 4);

    // Mid-run reset after 7 of 10 beats
    ctrl_len = '0;
    allow    = 1'b1;
    cycle();
    allow  = 1'b0;
    tvalid = 1'b1;
    tlast  = 1'b0;
    sent   = 0;
    for (int c = 0; (c < 50) && (sent < 7); c++) begin
      tdata = {$urandom, $urandom};
      cycle();
      if (m_acc) sent++;
    end
    tvalid = 1'b0;
    arst   = 1'b1;
    cycle();
    arst = 1'b0;
    check("rst_tready", tready0, 1'b0);
    check("rst_count", count0, 0);
    check("rst_empty0", empty0, 1'b0);
    check("rst_empty1", empty1, 1'b1);
    check("rst_fin", fin0, 1'b0);
    cycle();
    cycle();
    run_txn(0, 3, 2, 1, 1'b0, 64'h0, 1'b0);

    // Randomized transactions, one with CTRL_ALLOW held high
    for (int t = 0; t < 8; t++) begin
      len_v = $urandom_range(0, 6);
      nb    = $urandom_range(1, 8);
      last  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb - 1) : -1;
      if ((last < 0) && ((len_v == 0) || (len_v > nb))) last = nb - 1;
      run_txn(len_v, nb, last, 2, 1'b1, 64'h0, t == 3);
    end
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
